// File: rtl/dsp_ad_preadder_if.sv
// Operand bundle between the slice input stage and its neighbours:
// A/D operands, clock enables and INMODE in, cascade and multiplier/ALU operands out.
interface dsp_ad_preadder_if #(
    parameter int A_WIDTH = 30,
    parameter int D_WIDTH = 25
);
    // No handshake: every signal is sampled or driven on every cycle; enables only gate register loads.
    logic [A_WIDTH-1:0] a;
    logic [A_WIDTH-1:0] acin;
    logic [D_WIDTH-1:0] d;
    logic               cea1;
    logic               cea2;
    logic               ced;
    logic               cead;
    logic [3:0]         inmode;
    logic [A_WIDTH-1:0] acout;
    logic [A_WIDTH-1:0] a_alu;
    logic [D_WIDTH-1:0] a_mult;

    modport master (
        output a, acin, d, cea1, cea2, ced, cead, inmode,
        input  acout, a_alu, a_mult
    );

    modport slave (
        input  a, acin, d, cea1, cea2, ced, cead, inmode,
        output acout, a_alu, a_mult
    );
endinterface

// File: rtl/dsp_ad_preadder.sv
// Slice input stage: A1/A2 pipeline, D register, optional D+/-A pre-adder with AD register,
// feeding the multiplier A-side operand, the A cascade and the A:B ALU path.
module dsp_ad_preadder #(
    parameter int    A_WIDTH   = 30,
    parameter int    D_WIDTH   = 25,
    parameter int    AREG      = 1,
    parameter int    ACASCREG  = 1,
    parameter int    DREG      = 1,
    parameter int    ADREG     = 1,
    parameter string A_INPUT   = "DIRECT",
    parameter int    USE_DPORT = 0
) (
    input  logic             clk,
    input  logic             rst,
    dsp_ad_preadder_if.slave io
);
    logic [A_WIDTH-1:0] ain;
    logic [A_WIDTH-1:0] a1_out;
    logic [A_WIDTH-1:0] a2_out;
    logic [A_WIDTH-1:0] asel;
    logic [D_WIDTH-1:0] aterm;
    logic [D_WIDTH-1:0] d_out;
    logic [D_WIDTH-1:0] dterm;
    logic [D_WIDTH-1:0] ad;
    logic [D_WIDTH-1:0] ad_out;

    generate
        if (AREG < 0 || AREG > 2) begin : g_bad_areg
            $error("dsp_ad_preadder: AREG must be 0, 1 or 2");
        end
        if (ACASCREG < 0 || ACASCREG > 2 || ACASCREG > AREG) begin : g_bad_acascreg
            $error("dsp_ad_preadder: ACASCREG must be 0..2 and not exceed AREG");
        end
        if (AREG == 2 && ACASCREG == 0) begin : g_bad_casc_areg2
            $error("dsp_ad_preadder: AREG=2 needs at least one cascade register");
        end
        if ((DREG != 0 && DREG != 1) || (ADREG != 0 && ADREG != 1) ||
            (USE_DPORT != 0 && USE_DPORT != 1)) begin : g_bad_flags
            $error("dsp_ad_preadder: DREG, ADREG and USE_DPORT must be 0 or 1");
        end
        if (D_WIDTH > A_WIDTH) begin : g_bad_width
            $error("dsp_ad_preadder: D_WIDTH must not exceed A_WIDTH");
        end
        if (A_INPUT != "DIRECT" && A_INPUT != "CASCADE") begin : g_bad_src
            $error("dsp_ad_preadder: A_INPUT must be DIRECT or CASCADE");
        end

        if (A_INPUT == "DIRECT") begin : g_src_direct
            assign ain = io.a;
        end else begin : g_src_cascade
            assign ain = io.acin;
        end

        if (AREG == 2) begin : g_areg2
            logic [A_WIDTH-1:0] a1_q, a1_d;
            logic [A_WIDTH-1:0] a2_q, a2_d;
            assign a1_d = io.cea1 ? ain : a1_q;
            assign a2_d = io.cea2 ? a1_q : a2_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a1_q <= '0;
                    a2_q <= '0;
                end else begin
                    a1_q <= a1_d;
                    a2_q <= a2_d;
                end
            end
            assign a1_out = a1_q;
            assign a2_out = a2_q;
        end else if (AREG == 1) begin : g_areg1
            logic [A_WIDTH-1:0] a2_q, a2_d;
            assign a2_d = io.cea2 ? ain : a2_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) a2_q <= '0;
                else     a2_q <= a2_d;
            end
            assign a1_out = '0;
            assign a2_out = a2_q;
        end else begin : g_areg0
            assign a1_out = '0;
            assign a2_out = ain;
        end

        if (DREG == 1) begin : g_dreg
            logic [D_WIDTH-1:0] d_q, d_d;
            assign d_d = io.ced ? io.d : d_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) d_q <= '0;
                else     d_q <= d_d;
            end
            assign d_out = d_q;
        end else begin : g_dcomb
            assign d_out = io.d;
        end

        // The AD register only exists when the pre-adder actually drives the multiplier.
        if (USE_DPORT == 1 && ADREG == 1) begin : g_adreg
            logic [D_WIDTH-1:0] ad_q, ad_d;
            assign ad_d = io.cead ? ad : ad_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) ad_q <= '0;
                else     ad_q <= ad_d;
            end
            assign ad_out = ad_q;
        end else begin : g_adcomb
            assign ad_out = ad;
        end
    endgenerate

    // INMODE is unregistered; pre-add wraps modulo 2^D_WIDTH on the low A bits.
    always_comb begin
        asel  = (AREG == 2 && io.inmode[0]) ? a1_out : a2_out;
        aterm = io.inmode[1] ? '0 : asel[D_WIDTH-1:0];
        dterm = io.inmode[2] ? d_out : '0;
        ad    = io.inmode[3] ? (dterm - aterm) : (dterm + aterm);
    end

    assign io.a_alu  = a2_out;
    assign io.acout  = (AREG == 2 && ACASCREG == 1) ? a1_out : a2_out;
    assign io.a_mult = (USE_DPORT == 1) ? ad_out : aterm;

    logic unused_sink;
    assign unused_sink = ^{io.a, io.acin, io.d, io.cea1, io.ced, io.cead, asel, ad_out, d_out};
endmodule
